dp_sequencer: RTL

DP_SEQUENCER -- requirements
Module: dp_sequencer

---
 rtl/dp_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dp_sequencer.sv
// dp_sequencer: four-phase instruction sequencer for a register-bank datapath.
//
// Each accepted instruction walks IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
// The decoded control fields are driven from the instruction register, so they
// change when an instruction is accepted and otherwise hold their values.
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-high reset
//   instr[15:0]   in   instruction word {op_hi, Rdest, op_ext/imm_hi, Rsrc/imm_lo}
//   instr_valid   in   instr is presented
//   instr_ready   out  instruction accepted this cycle when valid
//   halt          in   blocks acceptance of new instructions
//   Flags_in[4:0] in   ALU flags from the datapath
//   wEnable[15:0] out  one-hot register-bank write enable (WRITEBACK only)
//   opcode[7:0]   out  ALU opcode
//   Rdest_select  out  destination register select
//   Rsrc_select   out  source register select
//   Imm_select    out  1 routes Imm_in into the ALU source
//   Imm_in[15:0]  out  sign-extended immediate
//   flags_q[4:0]  out  flags latched at the end of WRITEBACK
//   done          out  one-cycle retirement pulse (WRITEBACK)
//   retire_cnt    out  retired-instruction counter, wraps
//                      (only with DP_SEQUENCER_RETIRE_CNT_EN defined)
//
// Optional feature macro: DP_SEQUENCER_RETIRE_CNT_EN

module dp_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        halt,
   input  logic [4:0]  Flags_in,
   output logic [15:0] wEnable,
   output logic [7:0]  opcode,
   output logic [3:0]  Rdest_select,
   output logic [3:0]  Rsrc_select,
   output logic        Imm_select,
   output logic [15:0] Imm_in,
   output logic [4:0]  flags_q,
   output logic        done
`ifdef DP_SEQUENCER_RETIRE_CNT_EN
   ,
   output logic [15:0] retire_cnt
`endif
);

   // state     | meaning
   // IDLE      | waiting for instr_valid while not halted
   // DECODE    | control fields valid from the latched instruction
   // EXECUTE   | datapath computes
   // WRITEBACK | write enable and done asserted, flags captured at exit
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_DECODE    = 2'd1;
   localparam logic [1:0] S_EXECUTE   = 2'd2;
   localparam logic [1:0] S_WRITEBACK = 2'd3;

   logic [1:0]  r_state;
   logic [15:0] r_ir;
   logic [4:0]  r_flags;

   logic        w_accept;
   logic        w_imm_form;
   logic        w_is_cmp;
   logic        w_wb;
   logic [7:0]  w_opcode;

   assign instr_ready = (r_state == S_IDLE) && !halt;
   assign w_accept    = instr_valid && instr_ready;
   assign w_wb        = (r_state == S_WRITEBACK);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ir    <= 16'h0000;
         r_flags <= 5'b00000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ir    <= instr;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE:    r_state <= S_EXECUTE;
            S_EXECUTE:   r_state <= S_WRITEBACK;
            S_WRITEBACK: begin
               r_flags <= Flags_in;
               r_state <= S_IDLE;
            end
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   // Decode straight from IR: a cleared IR decodes to all-zero controls,
   // and the fields naturally hold while IDLE.
   assign w_imm_form = (r_ir[15:12] != 4'h0);
   assign w_opcode   = w_imm_form ? {r_ir[15:12], 4'h0} : {4'h0, r_ir[7:4]};
   assign w_is_cmp   = (w_opcode == 8'h0B) || (w_opcode == 8'hB0);

   assign opcode       = w_opcode;
   assign Rdest_select = r_ir[11:8];
   assign Rsrc_select  = w_imm_form ? 4'h0 : r_ir[3:0];
   assign Imm_select   = w_imm_form;
   assign Imm_in       = w_imm_form ? {{8{r_ir[7]}}, r_ir[7:0]} : 16'h0000;

   assign wEnable = (w_wb && !w_is_cmp) ? (16'h0001 << r_ir[11:8]) : 16'h0000;
   assign done    = w_wb;
   assign flags_q = r_flags;

`ifdef DP_SEQUENCER_RETIRE_CNT_EN
   logic [15:0] r_retire_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_retire_cnt <= 16'h0000;
      end else if (w_wb) begin
         r_retire_cnt <= r_retire_cnt + 16'h0001;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

endmodule
